// File: rtl/param_control_unit_pkg.sv
// Shared definitions for the multi-cycle bus CPU control unit: opcodes, FSM states and
// instruction field offsets.
package param_control_unit_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_MV   = 3'd0;
    localparam logic [OP_W-1:0] OP_MVI  = 3'd1;
    localparam logic [OP_W-1:0] OP_ADD  = 3'd2;
    localparam logic [OP_W-1:0] OP_SUB  = 3'd3;
    localparam logic [OP_W-1:0] OP_LD   = 3'd4;
    localparam logic [OP_W-1:0] OP_ST   = 3'd5;
    localparam logic [OP_W-1:0] OP_MVNZ = 3'd6;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EX1   = 3'd2,
        S_EX2   = 3'd3,
        S_EX3   = 3'd4
    } state_t;

    // Instruction layout from the MSB down: op, rx, ry.
    function automatic int rx_lsb(input int data_w, input int sel_w);
        return data_w - OP_W - sel_w;
    endfunction

    function automatic int ry_lsb(input int data_w, input int sel_w);
        return data_w - OP_W - 2 * sel_w;
    endfunction

endpackage

// File: rtl/param_control_unit_if.sv
// Control-unit <-> datapath signal bundle. master = control unit, slave = datapath/RAM side.
interface param_control_unit_if #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8
);

    // mem_ready is the only handshake: RAM raises it in the cycle read data is valid or a
    // write is accepted; the unit holds ram_out_ctrl/wr_enable steady until then and
    // consumes the transfer in that same cycle.
    logic              run;
    logic [DATA_W-1:0] instr;
    logic              mem_ready;
    logic              g_zero;
    logic [NREGS-1:0]  rin;
    logic [NREGS-1:0]  rout;
    logic              gin;
    logic              gout;
    logic              a_in;
    logic              addsub;
    logic              xorctrl;
    logic              pc_enable;
    logic              instr_enable;
    logic              ram_addr_sel;
    logic              ram_out_ctrl;
    logic              wr_enable;
    logic              imm_oe;
    logic [DATA_W-1:0] imm_out;
    logic              done;
    logic              illegal;

    modport master (
        input  run, instr, mem_ready, g_zero,
        output rin, rout, gin, gout, a_in, addsub, xorctrl, pc_enable, instr_enable,
               ram_addr_sel, ram_out_ctrl, wr_enable, imm_oe, imm_out, done, illegal
    );

    modport slave (
        output run, instr, mem_ready, g_zero,
        input  rin, rout, gin, gout, a_in, addsub, xorctrl, pc_enable, instr_enable,
               ram_addr_sel, ram_out_ctrl, wr_enable, imm_oe, imm_out, done, illegal
    );

endinterface

// File: rtl/param_control_unit_reg_decoder.sv
// Register select decoder: binary index plus enable to a one-hot strobe vector, with a flag
// for indices that name no physical register.
module param_control_unit_reg_decoder #(
    parameter int NREGS = 8,
    parameter int SEL_W = $clog2(NREGS)
) (
    input  logic [SEL_W-1:0] i_idx,
    input  logic             i_en,
    output logic [NREGS-1:0] o_onehot,
    output logic             o_out_of_range
);

    assign o_out_of_range = (int'(i_idx) >= NREGS);

    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (i_en && (int'(i_idx) == i)) begin
                o_onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/param_control_unit.sv
// Multi-cycle control FSM for the shared-bus CPU datapath: fetch with RAM wait states,
// then one to three execute cycles per opcode, stopping at an instruction boundary on !run.
module param_control_unit
    import param_control_unit_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int IMM_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    param_control_unit_if.master bus,
    output state_t               o_state
);

    localparam int SEL_W  = $clog2(NREGS);
    localparam int RX_LSB = rx_lsb(DATA_W, SEL_W);
    localparam int RY_LSB = ry_lsb(DATA_W, SEL_W);

    state_t           r_state;
    state_t           w_next;
    logic [OP_W-1:0]  w_op;
    logic [SEL_W-1:0] w_rx;
    logic [SEL_W-1:0] w_ry;
    logic [SEL_W-1:0] w_rout_idx;
    logic             w_rx_oor;
    logic             w_ry_oor;
    logic             w_rout_oor;
    logic             w_illegal_instr;
    logic             w_is_alu;
    logic             w_rout_use_ry;
    logic             w_rin_en;
    logic             w_rout_en;
    logic             w_done;
    logic             w_imm_oe;
    logic [NREGS-1:0] w_rin;
    logic [NREGS-1:0] w_rout;

    assign w_op            = bus.instr[DATA_W-1 -: OP_W];
    assign w_rx            = bus.instr[RX_LSB +: SEL_W];
    assign w_ry            = bus.instr[RY_LSB +: SEL_W];
    assign w_ry_oor        = (int'(w_ry) >= NREGS);
    assign w_is_alu        = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_XOR);
    assign w_illegal_instr = w_rx_oor | w_ry_oor | w_rout_oor;

    // rout addresses ry except when the ALU is fed rx (EX1) or a store drives its data (EX2).
    assign w_rout_use_ry = ((r_state == S_EX1) && !w_is_alu) ||
                           ((r_state == S_EX2) && w_is_alu);
    assign w_rout_idx    = w_rout_use_ry ? w_ry : w_rx;

    param_control_unit_reg_decoder #(.NREGS(NREGS), .SEL_W(SEL_W)) u_rin_dec (
        .i_idx          (w_rx),
        .i_en           (w_rin_en),
        .o_onehot       (w_rin),
        .o_out_of_range (w_rx_oor)
    );

    param_control_unit_reg_decoder #(.NREGS(NREGS), .SEL_W(SEL_W)) u_rout_dec (
        .i_idx          (w_rout_idx),
        .i_en           (w_rout_en),
        .o_onehot       (w_rout),
        .o_out_of_range (w_rout_oor)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // run is only looked at in IDLE and on the done cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.run) w_next = S_FETCH;
            S_FETCH: if (bus.mem_ready) w_next = S_EX1;
            S_EX1:   w_next = w_done ? (bus.run ? S_FETCH : S_IDLE) : S_EX2;
            S_EX2:   begin
                if (w_is_alu) begin
                    w_next = S_EX3;
                end else if (w_done) begin
                    w_next = bus.run ? S_FETCH : S_IDLE;
                end
            end
            S_EX3:   w_next = bus.run ? S_FETCH : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_rin_en         = 1'b0;
        w_rout_en        = 1'b0;
        w_done           = 1'b0;
        w_imm_oe         = 1'b0;
        bus.gin          = 1'b0;
        bus.gout         = 1'b0;
        bus.a_in         = 1'b0;
        bus.addsub       = 1'b0;
        bus.xorctrl      = 1'b0;
        bus.pc_enable    = 1'b0;
        bus.instr_enable = 1'b0;
        bus.ram_addr_sel = 1'b0;
        bus.ram_out_ctrl = 1'b0;
        bus.wr_enable    = 1'b0;
        bus.illegal      = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (bus.mem_ready) begin
                    bus.instr_enable = 1'b1;
                    bus.pc_enable    = 1'b1;
                end
            end
            S_EX1: begin
                if (w_illegal_instr) begin
                    bus.illegal = 1'b1;
                    w_done      = 1'b1;
                end else begin
                    case (w_op)
                        OP_MV: begin
                            w_rout_en = 1'b1;
                            w_rin_en  = 1'b1;
                            w_done    = 1'b1;
                        end
                        OP_MVI: begin
                            w_imm_oe = 1'b1;
                            w_rin_en = 1'b1;
                            w_done   = 1'b1;
                        end
                        OP_MVNZ: begin
                            w_rout_en = !bus.g_zero;
                            w_rin_en  = !bus.g_zero;
                            w_done    = 1'b1;
                        end
                        OP_ADD, OP_SUB, OP_XOR: begin
                            w_rout_en = 1'b1;
                            bus.a_in  = 1'b1;
                        end
                        default: begin
                            w_rout_en        = 1'b1;
                            bus.ram_addr_sel = 1'b1;
                        end
                    endcase
                end
            end
            S_EX2: begin
                if (w_is_alu) begin
                    w_rout_en   = 1'b1;
                    bus.gin     = 1'b1;
                    bus.addsub  = (w_op == OP_SUB);
                    bus.xorctrl = (w_op == OP_XOR);
                end else if (w_op == OP_LD) begin
                    bus.ram_addr_sel = 1'b1;
                    bus.ram_out_ctrl = 1'b1;
                    w_rin_en         = bus.mem_ready;
                    w_done           = bus.mem_ready;
                end else if (w_op == OP_ST) begin
                    bus.ram_addr_sel = 1'b1;
                    w_rout_en        = 1'b1;
                    bus.wr_enable    = 1'b1;
                    w_done           = bus.mem_ready;
                end
            end
            S_EX3: begin
                bus.gout = 1'b1;
                w_rin_en = 1'b1;
                w_done   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.rin     = w_rin;
    assign bus.rout    = w_rout;
    assign bus.done    = w_done;
    assign bus.imm_oe  = w_imm_oe;
    assign bus.imm_out = w_imm_oe ? DATA_W'(bus.instr[IMM_W-1:0]) : '0;
    assign o_state     = r_state;

endmodule

// File: tb/tb_param_control_unit.sv
// Directed bench for param_control_unit: an 8-register instance walks every opcode class,
// wait states and async reset; a 6-register instance covers illegal register fields.
module tb_param_control_unit;
    import param_control_unit_pkg::*;

    localparam logic [12:0] F_GIN  = 13'h1000;
    localparam logic [12:0] F_GOUT = 13'h0800;
    localparam logic [12:0] F_AIN  = 13'h0400;
    localparam logic [12:0] F_SUB  = 13'h0200;
    localparam logic [12:0] F_XOR  = 13'h0100;
    localparam logic [12:0] F_PC   = 13'h0080;
    localparam logic [12:0] F_IR   = 13'h0040;
    localparam logic [12:0] F_RAS  = 13'h0020;
    localparam logic [12:0] F_ROC  = 13'h0010;
    localparam logic [12:0] F_WR   = 13'h0008;
    localparam logic [12:0] F_IMM  = 13'h0004;
    localparam logic [12:0] F_DONE = 13'h0002;
    localparam logic [12:0] F_ILL  = 13'h0001;

    logic   clk;
    logic   rst;
    state_t st8;
    state_t st6;
    int     n_chk;
    int     n_err;

    param_control_unit_if #(.DATA_W(16), .NREGS(8)) if8 ();
    param_control_unit_if #(.DATA_W(16), .NREGS(6)) if6 ();

    param_control_unit #(.DATA_W(16), .NREGS(8), .IMM_W(8)) u_dut8 (
        .clk     (clk),
        .rst     (rst),
        .bus     (if8),
        .o_state (st8)
    );

    param_control_unit #(.DATA_W(16), .NREGS(6), .IMM_W(8)) u_dut6 (
        .clk     (clk),
        .rst     (rst),
        .bus     (if6),
        .o_state (st6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] flags8();
        return {if8.gin, if8.gout, if8.a_in, if8.addsub, if8.xorctrl, if8.pc_enable,
                if8.instr_enable, if8.ram_addr_sel, if8.ram_out_ctrl, if8.wr_enable,
                if8.imm_oe, if8.done, if8.illegal};
    endfunction

    function automatic logic [12:0] flags6();
        return {if6.gin, if6.gout, if6.a_in, if6.addsub, if6.xorctrl, if6.pc_enable,
                if6.instr_enable, if6.ram_addr_sel, if6.ram_out_ctrl, if6.wr_enable,
                if6.imm_oe, if6.done, if6.illegal};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input string tag,
                             input state_t st, input logic [7:0] rin, input logic [7:0] rout,
                             input logic [12:0] fl, input logic [15:0] imm,
                             input state_t e_st, input logic [7:0] e_rin, input logic [7:0] e_rout,
                             input logic [12:0] e_fl, input logic [15:0] e_imm);
        chk({tag, ".state"}, 32'(st), 32'(e_st));
        chk({tag, ".rin"}, 32'(rin), 32'(e_rin));
        chk({tag, ".rout"}, 32'(rout), 32'(e_rout));
        chk({tag, ".flags"}, 32'(fl), 32'(e_fl));
        chk({tag, ".imm_out"}, 32'(imm), 32'(e_imm));
    endtask

    task automatic check8(input string tag, input state_t e_st, input logic [7:0] e_rin,
                          input logic [7:0] e_rout, input logic [12:0] e_fl,
                          input logic [15:0] e_imm);
        @(negedge clk);
        check_all(tag, st8, if8.rin, if8.rout, flags8(), if8.imm_out,
                  e_st, e_rin, e_rout, e_fl, e_imm);
    endtask

    task automatic step8(input string tag, input state_t e_st, input logic [7:0] e_rin,
                         input logic [7:0] e_rout, input logic [12:0] e_fl,
                         input logic [15:0] e_imm);
        check8(tag, e_st, e_rin, e_rout, e_fl, e_imm);
        @(posedge clk);
        #1;
    endtask

    task automatic step6(input string tag, input state_t e_st, input logic [12:0] e_fl);
        @(negedge clk);
        check_all(tag, st6, {2'b00, if6.rin}, {2'b00, if6.rout}, flags6(), if6.imm_out,
                  e_st, 8'h00, 8'h00, e_fl, 16'h0000);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        if8.run = 1'b0; if8.instr = '0; if8.mem_ready = 1'b0; if8.g_zero = 1'b0;
        if6.run = 1'b0; if6.instr = '0; if6.mem_ready = 1'b0; if6.g_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        if8.run = 1'b1; if8.mem_ready = 1'b1;
        step8("reset", S_IDLE, 8'h00, 8'h00, 13'h0, 16'h0);
        rst = 1'b0;

        // MVI r3,#0xA5
        if8.instr = 16'h2CA5;
        step8("mvi_idle", S_IDLE, 8'h00, 8'h00, 13'h0, 16'h0);
        step8("mvi_fetch", S_FETCH, 8'h00, 8'h00, F_PC | F_IR, 16'h0);
        step8("mvi_ex1", S_EX1, 8'h08, 8'h00, F_IMM | F_DONE, 16'h00A5);

        // SUB r1,r2
        if8.instr = 16'h6500;
        step8("sub_fetch", S_FETCH, 8'h00, 8'h00, F_PC | F_IR, 16'h0);
        step8("sub_ex1", S_EX1, 8'h00, 8'h02, F_AIN, 16'h0);
        step8("sub_ex2", S_EX2, 8'h00, 8'h04, F_GIN | F_SUB, 16'h0);
        step8("sub_ex3", S_EX3, 8'h02, 8'h00, F_GOUT | F_DONE, 16'h0);

        // LD r0,[r5] with three wait cycles
        if8.instr = 16'h8280;
        step8("ld_fetch", S_FETCH, 8'h00, 8'h00, F_PC | F_IR, 16'h0);
        step8("ld_ex1", S_EX1, 8'h00, 8'h20, F_RAS, 16'h0);
        if8.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step8("ld_wait", S_EX2, 8'h00, 8'h00, F_RAS | F_ROC, 16'h0);
        end
        if8.mem_ready = 1'b1;
        step8("ld_ex2", S_EX2, 8'h01, 8'h00, F_RAS | F_ROC | F_DONE, 16'h0);

        // ST r6,[r2] with a fetch wait and a write wait
        if8.instr = 16'hB900;
        if8.mem_ready = 1'b0;
        step8("st_fetch_wait", S_FETCH, 8'h00, 8'h00, 13'h0, 16'h0);
        if8.mem_ready = 1'b1;
        step8("st_fetch", S_FETCH, 8'h00, 8'h00, F_PC | F_IR, 16'h0);
        step8("st_ex1", S_EX1, 8'h00, 8'h04, F_RAS, 16'h0);
        if8.mem_ready = 1'b0;
        step8("st_wait", S_EX2, 8'h00, 8'h40, F_RAS | F_WR, 16'h0);
        if8.mem_ready = 1'b1;
        step8("st_ex2", S_EX2, 8'h00, 8'h40, F_RAS | F_WR | F_DONE, 16'h0);

        // MVNZ r4,r7 with G zero, then nonzero
        if8.instr = 16'hD380;
        if8.g_zero = 1'b1;
        step8("mvnz_z_fetch", S_FETCH, 8'h00, 8'h00, F_PC | F_IR, 16'h0);
        step8("mvnz_z_ex1", S_EX1, 8'h00, 8'h00, F_DONE, 16'h0);
        if8.g_zero = 1'b0;
        step8("mvnz_nz_fetch", S_FETCH, 8'h00, 8'h00, F_PC | F_IR, 16'h0);
        step8("mvnz_nz_ex1", S_EX1, 8'h10, 8'h80, F_DONE, 16'h0);

        // MV r2,r2
        if8.instr = 16'h0900;
        step8("mv_fetch", S_FETCH, 8'h00, 8'h00, F_PC | F_IR, 16'h0);
        step8("mv_ex1", S_EX1, 8'h04, 8'h04, F_DONE, 16'h0);

        // XOR r7,r0, stopping afterwards
        if8.instr = 16'hFC00;
        step8("xor_fetch", S_FETCH, 8'h00, 8'h00, F_PC | F_IR, 16'h0);
        step8("xor_ex1", S_EX1, 8'h00, 8'h80, F_AIN, 16'h0);
        step8("xor_ex2", S_EX2, 8'h00, 8'h01, F_GIN | F_XOR, 16'h0);
        if8.run = 1'b0;
        step8("xor_ex3", S_EX3, 8'h80, 8'h00, F_GOUT | F_DONE, 16'h0);
        step8("xor_idle", S_IDLE, 8'h00, 8'h00, 13'h0, 16'h0);
        step8("idle_hold", S_IDLE, 8'h00, 8'h00, 13'h0, 16'h0);

        // ADD r1,r3 aborted by reset in EX2
        if8.run = 1'b1;
        if8.instr = 16'h4580;
        step8("add_idle", S_IDLE, 8'h00, 8'h00, 13'h0, 16'h0);
        step8("add_fetch", S_FETCH, 8'h00, 8'h00, F_PC | F_IR, 16'h0);
        step8("add_ex1", S_EX1, 8'h00, 8'h02, F_AIN, 16'h0);
        check8("add_ex2", S_EX2, 8'h00, 8'h08, F_GIN, 16'h0);
        rst = 1'b1;
        #1;
        chk("rst_async.state", 32'(st8), 32'(S_IDLE));
        chk("rst_async.done", 32'(if8.done), 32'd0);
        @(posedge clk);
        #1;
        check8("rst_hold", S_IDLE, 8'h00, 8'h00, 13'h0, 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        if8.run = 1'b0;
        step8("rst_release", S_IDLE, 8'h00, 8'h00, 13'h0, 16'h0);

        // NREGS=6: rx=7 is illegal, run low at that done
        if6.run = 1'b1;
        if6.mem_ready = 1'b1;
        if6.instr = 16'h1C00;
        step6("ill_idle", S_IDLE, 13'h0);
        step6("ill_fetch", S_FETCH, F_PC | F_IR);
        if6.run = 1'b0;
        step6("ill_ex1", S_EX1, F_DONE | F_ILL);
        step6("ill_stop1", S_IDLE, 13'h0);
        step6("ill_stop2", S_IDLE, 13'h0);

        // NREGS=6: LD with ry=6 is illegal, run high carries on to FETCH
        if6.run = 1'b1;
        if6.instr = 16'h8300;
        step6("ill2_idle", S_IDLE, 13'h0);
        step6("ill2_fetch", S_FETCH, F_PC | F_IR);
        step6("ill2_ex1", S_EX1, F_DONE | F_ILL);
        step6("ill2_next", S_FETCH, F_PC | F_IR);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
